dmem_mmio: RTL and testbench



---
 rtl/dmem_mmio_pkg.sv | 41 ++++
 rtl/dmem_mmio_sync_fifo.sv | 67 ++++++
 rtl/dmem_mmio.sv | 144 ++++++++++++++
 tb/tb_dmem_mmio.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/dmem_mmio_pkg.sv
// ============================================================================
// dmem_mmio_pkg : shared memory map for the data-memory responder
//                 (region codes, MMIO word offsets, CON_STAT bit positions)
// Revision      : 1.0 - initial release
// ============================================================================
`default_nettype none

package dmem_mmio_pkg;

    typedef enum logic [1:0] {
        REGION_RAM   = 2'b00,
        REGION_UNMP0 = 2'b01,
        REGION_UNMP1 = 2'b10,
        REGION_MMIO  = 2'b11
    } region_e;

    localparam logic [3:0] MMIO_LEDS     = 4'd0;
    localparam logic [3:0] MMIO_CYCLE_LO = 4'd1;
    localparam logic [3:0] MMIO_CYCLE_HI = 4'd2;
    localparam logic [3:0] MMIO_CON_TX   = 4'd3;
    localparam logic [3:0] MMIO_CON_STAT = 4'd4;

    localparam int STAT_EMPTY = 1;
    localparam int STAT_FULL  = 2;
    localparam int STAT_HALF  = 3;
    localparam int STAT_OVF   = 4;

    // Replace only the byte lanes selected by mask.
    function automatic logic [31:0] lane_merge(input logic [31:0] old_w,
                                               input logic [31:0] new_w,
                                               input logic [3:0]  mask);
        logic [31:0] res;
        for (int n = 0; n < 4; n++) begin
            res[8*n +: 8] = mask[n] ? new_w[8*n +: 8] : old_w[8*n +: 8];
        end
        return res;
    endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_mmio_sync_fifo.sv
// ============================================================================
// sync_fifo : single-clock FIFO; pushes into a full FIFO and pops from an
//             empty one are ignored, head reads 0 while empty
// Revision  : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic [WIDTH-1:0]           i_data,
    output logic [WIDTH-1:0]           o_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] buf_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q,  count_d;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign o_full    = (count_q == CW'(DEPTH));
    assign o_empty   = (count_q == '0);
    assign o_count   = count_q;
    assign o_data    = o_empty ? '0 : buf_q[rd_ptr_q];
    assign w_push_ok = i_push && !o_full;
    assign w_pop_ok  = i_pop && !o_empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CW'(w_push_ok) - CW'(w_pop_ok);
        if (w_push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
        if (w_pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the head is masked to 0 whenever count is 0.
    always_ff @(posedge clk) begin
        if (w_push_ok) buf_q[wr_ptr_q] <= i_data;
    end

endmodule

`default_nettype wire

// File: rtl/dmem_mmio.sv
// ============================================================================
// dmem_mmio : data-memory port responder - word RAM plus MMIO block with
//             LED register, 64-bit cycle counter and console TX FIFO
// Revision  : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_mmio
    import dmem_mmio_pkg::*;
#(
    parameter int RAM_AW    = 10,
    parameter int CON_DEPTH = 4,
    parameter     INIT_FILE = ""
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [29:0] i_mem_addr,
    input  logic [31:0] i_mem_data,
    input  logic        i_mem_we,
    input  logic [3:0]  i_mem_mask,
    output logic [31:0] o_mem_data,
    output logic [15:0] o_leds,
    output logic [7:0]  o_con_data,
    output logic        o_con_valid,
    input  logic        i_con_ready
);

    localparam int CON_CW = $clog2(CON_DEPTH) + 1;

    logic [31:0]       mem_q [2**RAM_AW];
    logic [15:0]       leds_q, leds_d;
    logic [63:0]       cyc_q,  cyc_d;
    logic              ovf_q,  ovf_d;

    region_e           w_region;
    logic [RAM_AW-1:0] w_ram_idx;
    logic [3:0]        w_off;
    logic              w_is_ram;
    logic              w_is_mmio;
    logic              w_ram_we;
    logic              w_con_push;
    logic              w_con_pop;
    logic              w_con_full;
    logic              w_con_empty;
    logic [CON_CW-1:0] w_con_count;
    logic [31:0]       w_con_stat;
    logic              w_unused_addr;

    assign w_region      = region_e'(i_mem_addr[29:28]);
    assign w_ram_idx     = i_mem_addr[RAM_AW-1:0];
    assign w_off         = i_mem_addr[3:0];
    assign w_is_ram      = (w_region == REGION_RAM);
    assign w_is_mmio     = (w_region == REGION_MMIO);
    assign w_ram_we      = i_mem_we && w_is_ram;
    assign w_unused_addr = ^i_mem_addr[27:RAM_AW];

    // RAM is intentionally left out of reset so program data survives it.
    always_ff @(posedge clk) begin
        if (w_ram_we) mem_q[w_ram_idx] <= lane_merge(mem_q[w_ram_idx], i_mem_data, i_mem_mask);
    end

    always_comb begin
        leds_d     = leds_q;
        cyc_d      = cyc_q + 64'd1;
        ovf_d      = ovf_q;
        w_con_push = 1'b0;
        if (i_mem_we && w_is_mmio) begin
            case (w_off)
                MMIO_LEDS: begin
                    if (i_mem_mask[0]) leds_d[7:0]  = i_mem_data[7:0];
                    if (i_mem_mask[1]) leds_d[15:8] = i_mem_data[15:8];
                end
                MMIO_CON_TX: begin
                    // Overflow is judged on the pre-edge full flag, so a
                    // concurrent pop never rescues the push.
                    w_con_push = i_mem_mask[0];
                    if (i_mem_mask[0] && w_con_full) ovf_d = 1'b1;
                end
                MMIO_CON_STAT: begin
                    if (i_mem_mask[0] && i_mem_data[STAT_OVF]) ovf_d = 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            leds_q <= '0;
            cyc_q  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            leds_q <= leds_d;
            cyc_q  <= cyc_d;
            ovf_q  <= ovf_d;
        end
    end

    assign w_con_pop = o_con_valid && i_con_ready;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (CON_DEPTH)
    ) u_con_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_con_push),
        .i_pop   (w_con_pop),
        .i_data  (i_mem_data[7:0]),
        .o_data  (o_con_data),
        .o_full  (w_con_full),
        .o_empty (w_con_empty),
        .o_count (w_con_count)
    );

    assign o_con_valid = !w_con_empty;
    assign o_leds      = leds_q;

    always_comb begin
        w_con_stat             = '0;
        w_con_stat[STAT_EMPTY] = w_con_empty;
        w_con_stat[STAT_FULL]  = w_con_full;
        w_con_stat[STAT_HALF]  = (w_con_count >= CON_CW'(CON_DEPTH / 2));
        w_con_stat[STAT_OVF]   = ovf_q;
    end

    always_comb begin
        o_mem_data = '0;
        if (w_is_ram) begin
            o_mem_data = mem_q[w_ram_idx];
        end else if (w_is_mmio) begin
            case (w_off)
                MMIO_LEDS:     o_mem_data = {16'h0000, leds_q};
                MMIO_CYCLE_LO: o_mem_data = cyc_q[31:0];
                MMIO_CYCLE_HI: o_mem_data = cyc_q[63:32];
                MMIO_CON_STAT: o_mem_data = w_con_stat;
                default:       o_mem_data = '0;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_dmem_mmio.sv
// ============================================================================
// tb_dmem_mmio : directed + random stimulus against a queue/array model
// Revision     : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmem_mmio;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [29:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [3:0]  mask;
    logic        ready;
    logic [31:0] o_mem_data;
    logic [15:0] o_leds;
    logic [7:0]  o_con_data;
    logic        o_con_valid;

    always #5 clk = ~clk;

    dmem_mmio #(.RAM_AW(10), .CON_DEPTH(4), .INIT_FILE("")) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_mem_addr  (addr),
        .i_mem_data  (wdata),
        .i_mem_we    (we),
        .i_mem_mask  (mask),
        .o_mem_data  (o_mem_data),
        .o_leds      (o_leds),
        .o_con_data  (o_con_data),
        .o_con_valid (o_con_valid),
        .i_con_ready (ready)
    );

    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_ram [0:1023];
    logic [15:0] m_leds;
    logic [63:0] m_cyc;
    logic        m_ovf;
    logic [7:0]  m_q [$];

    function automatic logic [29:0] ram_a(input int idx);
        return {2'b00, 28'(idx)};
    endfunction

    function automatic logic [29:0] mmio_a(input int off);
        return {2'b11, 24'h0, 4'(off)};
    endfunction

    function automatic logic [31:0] m_stat();
        int n = m_q.size();
        return {27'b0, m_ovf, (n >= 2), (n == 4), (n == 0), 1'b0};
    endfunction

    function automatic logic [31:0] m_read(input logic [29:0] a);
        if (a[29:28] == 2'b00) return m_ram[a[9:0]];
        if (a[29:28] != 2'b11) return 32'h0;
        case (a[3:0])
            4'd0:    return {16'h0, m_leds};
            4'd1:    return m_cyc[31:0];
            4'd2:    return m_cyc[63:32];
            4'd4:    return m_stat();
            default: return 32'h0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One bus cycle: drive, compare against the pre-edge model, advance model.
    task automatic step(input logic [29:0] a, input logic [31:0] d,
                        input logic w, input logic [3:0] m, input logic r);
        logic [31:0] exp_rd;
        logic        full_pre;
        addr = a; wdata = d; we = w; mask = m; ready = r;
        #1;
        exp_rd = m_read(a);
        if (!$isunknown(exp_rd)) chk("rdata", o_mem_data, exp_rd);
        chk("con_valid", o_con_valid, m_q.size() != 0);
        chk("con_data", o_con_data, (m_q.size() != 0) ? m_q[0] : 8'h00);
        chk("leds", o_leds, m_leds);
        full_pre = (m_q.size() == 4);
        if (m_q.size() != 0 && r) void'(m_q.pop_front());
        if (w) begin
            if (a[29:28] == 2'b00) begin
                for (int n = 0; n < 4; n++)
                    if (m[n]) m_ram[a[9:0]][8*n +: 8] = d[8*n +: 8];
            end else if (a[29:28] == 2'b11) begin
                case (a[3:0])
                    4'd0: begin
                        if (m[0]) m_leds[7:0]  = d[7:0];
                        if (m[1]) m_leds[15:8] = d[15:8];
                    end
                    4'd3: if (m[0]) begin
                        if (full_pre) m_ovf = 1'b1;
                        else          m_q.push_back(d[7:0]);
                    end
                    4'd4: if (m[0] && d[4]) m_ovf = 1'b0;
                    default: ;
                endcase
            end
        end
        m_cyc = m_cyc + 64'd1;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [29:0] ra;
        rst_n = 1'b0; addr = '0; wdata = '0; we = 1'b0; mask = '0; ready = 1'b0;
        m_leds = '0; m_cyc = '0; m_ovf = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_leds", o_leds, 16'h0);
        chk("rst_valid", o_con_valid, 1'b0);
        chk("rst_con_data", o_con_data, 8'h0);
        @(negedge clk);
        rst_n = 1'b1;

        step(mmio_a(1), 0, 0, 4'h0, 0);
        step(mmio_a(2), 0, 0, 4'h0, 0);
        for (int i = 0; i < 16; i++) step(ram_a(i), $urandom, 1, 4'hF, 0);

        // Byte masks and aliasing
        step(ram_a(5), 32'hAABBCCDD, 1, 4'hF, 0);
        step(ram_a(5), 32'h11223344, 1, 4'h5, 0);
        step(ram_a(5), 0, 1, 4'h0, 0);
        addr = ram_a(5 + 1024); we = 1'b0;
        #1 chk("ram_alias", o_mem_data, 32'hAA22CC44);
        step(ram_a(5 + 1024), 0, 0, 4'h0, 0);

        // Read-during-write: old value this cycle, new value after the edge
        step(ram_a(5), 32'h0, 1, 4'hF, 0);
        #1 chk("rdw_new", o_mem_data, 32'h0);

        // Counter run and 32-bit carry
        repeat (100) step(mmio_a(1), 0, 0, 4'h0, 0);
        force dut.cyc_q = 64'h0000_0000_FFFF_FFFF;
        #1 release dut.cyc_q;
        m_cyc = 64'h0000_0000_FFFF_FFFF;
        step(mmio_a(1), 0, 0, 4'h0, 0);
        step(mmio_a(1), 0, 0, 4'h0, 0);
        step(mmio_a(2), 0, 0, 4'h0, 0);

        // Console fill, overflow, drain, W1C
        for (int b = 0; b < 4; b++) step(mmio_a(3), 32'h41 + b, 1, 4'h1, 0);
        step(mmio_a(4), 0, 0, 4'h0, 0);
        step(mmio_a(3), 32'h45, 1, 4'h1, 0);
        step(mmio_a(3), 32'h46, 1, 4'h2, 0);
        step(mmio_a(4), 0, 0, 4'h0, 0);
        repeat (5) step(mmio_a(4), 0, 0, 4'h0, 1);
        step(mmio_a(4), 32'h10, 1, 4'h1, 0);
        step(mmio_a(4), 0, 0, 4'h0, 0);

        // Simultaneous push+pop at count 2 and at full
        step(mmio_a(3), 32'h50, 1, 4'h1, 0);
        step(mmio_a(3), 32'h51, 1, 4'h1, 0);
        step(mmio_a(3), 32'h52, 1, 4'h1, 1);
        step(mmio_a(4), 0, 0, 4'h0, 0);
        step(mmio_a(3), 32'h53, 1, 4'h1, 0);
        step(mmio_a(3), 32'h54, 1, 4'h1, 0);
        step(mmio_a(3), 32'h55, 1, 4'h1, 1);
        step(mmio_a(4), 0, 0, 4'h0, 0);
        repeat (4) step(mmio_a(4), 0, 0, 4'h0, 1);
        step(mmio_a(4), 32'h10, 1, 4'h1, 0);

        // Random traffic across all regions
        for (int k = 0; k < 400; k++) begin
            case ($urandom_range(0, 3))
                0: ra = {2'b00, 18'($urandom), 6'b0, 4'($urandom)};
                1: ra = {2'b11, 24'($urandom), 4'($urandom)};
                2: ra = {2'b11, 24'($urandom), 4'($urandom_range(0, 4))};
                default: ra = {2'($urandom_range(1, 2)), 28'($urandom)};
            endcase
            step(ra, $urandom, 1'($urandom), 4'($urandom), 1'($urandom));
        end

        // Asynchronous reset mid-stream
        step(mmio_a(4), 32'h10, 1, 4'h1, 1);
        repeat (4) step(mmio_a(4), 0, 0, 4'h0, 1);
        for (int b = 0; b < 3; b++) step(mmio_a(3), 32'h61 + b, 1, 4'h1, 0);
        step(mmio_a(0), 32'h0000_00A5, 1, 4'h3, 0);
        step(mmio_a(0), 0, 0, 4'h0, 0);
        addr = ram_a(5); we = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", o_con_valid, 1'b0);
        chk("arst_leds", o_leds, 16'h0);
        chk("arst_con_data", o_con_data, 8'h0);
        chk("arst_ram", o_mem_data, m_ram[5]);
        m_q.delete(); m_leds = '0; m_ovf = 1'b0; m_cyc = '0;
        @(negedge clk);
        rst_n = 1'b1;
        step(mmio_a(4), 0, 0, 4'h0, 1);
        step(mmio_a(1), 0, 0, 4'h0, 0);
        step(ram_a(3), 0, 0, 4'h0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
